joust2_rom_loader: RTL
======================

Name: joust2_rom_loader

Overview:
- Sits between hps_io's ioctl download stream and the williams2 core's ROM memories; upstream of the core.
- Decodes each downloaded byte's linear address into one of four ROM regions and presents it as a region-local write.
- Buffers writes in a 2-entry FIFO because region memories accept a write only when mem_ready is high.
- Holds the core in reset from download start until the last byte has been written.

Parameters:
- ROM_INDEX, 0, ioctl_index value that selects ROM download; other indices are ignored
- MAIN_END, 17'h0FFFF, last address of the main CPU region; the region starts at 0
- SND_END, 17'h13FFF, last address of the sound CPU region
- GFX_END, 17'h1BFFF, last address of the graphics region
- PROM_END, 17'h1C3FF, last address of the decoder PROM region; addresses above it are dropped

Ports:
- clk_sys  in  1  system clock (12 MHz)
- reset  in  1  synchronous, active-high
- ioctl_download  in  1  download active
- ioctl_index  in  8  download index
- ioctl_wr  in  1  one-cycle byte strobe
- ioctl_addr  in  17  linear byte address
- ioctl_dout  in  8  byte data
- ioctl_wait  out  1  backpressure to hps_io
- mem_ready  in  1  region memories accept a write this cycle
- rom_we  out  4  one-hot write enable: [0] main, [1] sound, [2] gfx, [3] prom
- rom_addr  out  16  region-relative address (linear address minus region base)
- rom_data  out  8  write data
- core_reset  out  1  reset to the williams2 core
- rom_loaded  out  1  sticky flag: a complete download has finished
- drop_count  out  8  count of out-of-map bytes, saturating at 255

Behaviour:
- Reset values: ioctl_wait=0, rom_we=0, rom_addr=0, rom_data=0, core_reset=1, rom_loaded=0, drop_count=0; FIFO empty; state IDLE.
- A byte is accepted in a cycle when ioctl_download=1, ioctl_index=ROM_INDEX and ioctl_wr=1.
- Address decode is registered in the accept cycle:
  - addr<=MAIN_END -> main
  - addr<=SND_END -> sound
  - addr<=GFX_END -> gfx
  - addr<=PROM_END -> prom
  - otherwise the byte is dropped: drop_count+1 (saturating) and no FIFO push.
- FIFO: 2 entries of {region[1:0], addr[15:0], data[7:0]}.
  - ioctl_wait=1 whenever occupancy>=1; this is registered, updated each cycle.
  - An accept while the FIFO is full is a protocol error: the byte is discarded, drop_count increments, and the FIFO is not corrupted.
  - A push and a pop in the same cycle are both honoured; occupancy is unchanged.
- Write port: when the FIFO is non-empty and mem_ready=1, the head entry is popped and rom_we[region], rom_addr and rom_data are driven for exactly one cycle.
  - The write appears 1 cycle after the pop decision, so best-case ioctl_wr to rom_we latency is 2 cycles.
  - rom_we is 0 in all other cycles; rom_addr and rom_data hold their last value.
- State machine:
  - IDLE: core_reset follows reset. Goes to LOAD on the rising edge of ioctl_download with index match.
  - LOAD: core_reset=1, drop_count cleared on entry. Goes to FLUSH when ioctl_download falls.
  - FLUSH: core_reset=1. Goes to DONE when the FIFO is empty and no write is in flight.
  - DONE: rom_loaded<=1, core_reset=1 for this one cycle, then IDLE.
- A download with a non-matching index never leaves IDLE and never asserts ioctl_wait.
- If ioctl_download falls with bytes still queued, all queued bytes are still written before DONE.
- reset mid-operation: FIFO flushed, state IDLE, rom_loaded cleared; any pending writes are lost.
- A new download while rom_loaded=1 re-enters LOAD; rom_loaded stays 1.

Optional Feature:
- Macro: JOUST2_ROM_LOADER_CKSUM_EN.
- When defined:
  - Adds output rom_cksum [15:0], the modulo-2^16 sum of all bytes written to regions during the last download.
  - The sum is cleared on entry to LOAD and frozen in DONE.
  - Dropped bytes are excluded.
  - Reset value 0.
- When undefined, the port and its adder are absent and behaviour is otherwise identical.

Decomposition:
- Package joust2_loader_pkg holds:
  - region enum REG_MAIN/REG_SND/REG_GFX/REG_PROM
  - loader state enum
  - FIFO entry struct
  - default region end constants
- One sub-module: joust2_loader_fifo, a 2-entry synchronous FIFO with push, pop, full, empty and count.

Test Plan:
- Download with mem_ready tied 1: byte 0xA5 at 0x00010 -> rom_we=4'b0001, rom_addr=0x0010, rom_data=0xA5, two cycles after ioctl_wr.
- Region boundaries:
  - 0x0FFFF -> main, addr 0xFFFF
  - 0x10000 -> sound, addr 0x0000
  - 0x14000 -> gfx, addr 0x0000
  - 0x1C3FF -> prom, addr 0x03FF
  - 0x1C400 -> no write, drop_count=1
- mem_ready held 0 for 10 cycles after 1 byte -> ioctl_wait=1 throughout, no rom_we; when mem_ready rises, exactly one write occurs and ioctl_wait falls.
- ioctl_index=1 stream -> no rom_we, core_reset=0, state stays IDLE.
- ioctl_download falls with 2 bytes queued and mem_ready low -> core_reset stays 1; after mem_ready rises, 2 writes occur, then rom_loaded=1 and core_reset=0 the following cycle.
- reset asserted during LOAD with 1 byte queued -> no further rom_we, rom_loaded=0, ioctl_wait=0 on the next cycle.
- (CKSUM_EN build) write 0xFF, 0x02 -> rom_cksum=0x0101 at DONE.

Source files
------------

// File: rtl/joust2_loader_pkg.sv
// joust2_loader_pkg: shared types and default region map for the joust2 ROM loader
package joust2_loader_pkg;
  typedef enum logic [1:0] {REG_MAIN, REG_SND, REG_GFX, REG_PROM} region_e;
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DONE} state_e;
  typedef struct packed {
    region_e     region;
    logic [15:0] addr;
    logic [7:0]  data;
  } fifo_entry_t;
  localparam logic [16:0] DEF_MAIN_END = 17'h0FFFF;
  localparam logic [16:0] DEF_SND_END  = 17'h13FFF;
  localparam logic [16:0] DEF_GFX_END  = 17'h1BFFF;
  localparam logic [16:0] DEF_PROM_END = 17'h1C3FF;
endpackage

// File: rtl/joust2_rom_loader_if.sv
// joust2_rom_loader_if: ioctl download stream and region write port of the ROM loader
interface joust2_rom_loader_if;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [16:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic        mem_ready;
  logic [3:0]  rom_we;
  logic [15:0] rom_addr;
  logic [7:0]  rom_data;
  modport master (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, mem_ready,
    input  ioctl_wait, rom_we, rom_addr, rom_data
  );
  modport slave (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, mem_ready,
    output ioctl_wait, rom_we, rom_addr, rom_data
  );
endinterface

// File: rtl/joust2_loader_fifo.sv
// joust2_loader_fifo: 2-entry synchronous FIFO of decoded region writes
module joust2_loader_fifo
  import joust2_loader_pkg::*;
(
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        push,
  input  fifo_entry_t din,
  input  logic        pop,
  output fifo_entry_t dout,
  output logic        full,
  output logic        empty,
  output logic [1:0]  count
);
  fifo_entry_t mem [2];
  logic wr_ptr, rd_ptr, do_push, do_pop;
  assign full    = count == 2'd2;
  assign empty   = count == 2'd0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= !wr_ptr;
      end
      if (do_pop) rd_ptr <= !rd_ptr;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end
endmodule

// File: rtl/joust2_rom_loader.sv
// joust2_rom_loader: ioctl-to-ROM region writer with core reset hold; JOUST2_ROM_LOADER_CKSUM_EN adds rom_cksum
module joust2_rom_loader
  import joust2_loader_pkg::*;
#(
  parameter logic [7:0]  ROM_INDEX = 8'd0,
  parameter logic [16:0] MAIN_END  = DEF_MAIN_END,
  parameter logic [16:0] SND_END   = DEF_SND_END,
  parameter logic [16:0] GFX_END   = DEF_GFX_END,
  parameter logic [16:0] PROM_END  = DEF_PROM_END
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  joust2_rom_loader_if.slave   bus,
  output logic                 core_reset,
  output logic                 rom_loaded,
  output logic [7:0]           drop_count
`ifdef JOUST2_ROM_LOADER_CKSUM_EN
  ,
  output logic [15:0]          rom_cksum
`endif
);
  state_e      state, state_nx;
  region_e     region;
  fifo_entry_t entry, head;
  logic [16:0] base;
  logic [1:0]  count, occ_nx;
  logic [7:0]  drop_base;
  logic        dl_q, idx_ok, accept, push, pop, drop, full, empty, enter_load;
  assign idx_ok     = bus.ioctl_index == ROM_INDEX;
  assign accept     = bus.ioctl_download && idx_ok && bus.ioctl_wr;
  assign push       = accept && bus.ioctl_addr <= PROM_END && !full;
  assign drop       = accept && !push;
  assign pop        = !empty && bus.mem_ready;
  assign occ_nx     = count + {1'b0, push} - {1'b0, pop};
  assign enter_load = state == S_IDLE && state_nx == S_LOAD;
  assign drop_base  = enter_load ? 8'd0 : drop_count;
  assign entry      = '{region: region, addr: 16'(bus.ioctl_addr - base), data: bus.ioctl_dout};
  always_comb begin
    region = bus.ioctl_addr <= MAIN_END ? REG_MAIN :
             bus.ioctl_addr <= SND_END  ? REG_SND  :
             bus.ioctl_addr <= GFX_END  ? REG_GFX  : REG_PROM;
    base   = region == REG_MAIN ? 17'd0 :
             region == REG_SND  ? MAIN_END + 17'd1 :
             region == REG_GFX  ? SND_END + 17'd1  : GFX_END + 17'd1;
  end
  joust2_loader_fifo u_fifo (
    .clk_sys (clk_sys),
    .reset   (reset),
    .push    (push),
    .din     (entry),
    .pop     (pop),
    .dout    (head),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );
  // FLUSH waits for the registered write of the last pop to retire too
  always_comb begin
    state_nx   = state;
    core_reset = 1'b1;
    case (state)
      S_IDLE: begin
        core_reset = reset;
        state_nx   = bus.ioctl_download && !dl_q && idx_ok ? S_LOAD : S_IDLE;
      end
      S_LOAD:  state_nx = bus.ioctl_download ? S_LOAD : S_FLUSH;
      S_FLUSH: state_nx = empty && bus.rom_we == 4'd0 ? S_DONE : S_FLUSH;
      default: state_nx = S_IDLE;
    endcase
  end
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state          <= S_IDLE;
      dl_q           <= 1'b0;
      bus.ioctl_wait <= 1'b0;
      bus.rom_we     <= 4'd0;
      bus.rom_addr   <= 16'd0;
      bus.rom_data   <= 8'd0;
      rom_loaded     <= 1'b0;
      drop_count     <= 8'd0;
    end else begin
      state          <= state_nx;
      dl_q           <= bus.ioctl_download;
      bus.ioctl_wait <= occ_nx != 2'd0;
      bus.rom_we     <= pop ? 4'b0001 << head.region : 4'd0;
      if (pop) begin
        bus.rom_addr <= head.addr;
        bus.rom_data <= head.data;
      end
      if (state == S_DONE) rom_loaded <= 1'b1;
      drop_count <= drop_base + {7'd0, drop && drop_base != 8'hFF};
    end
  end
`ifdef JOUST2_ROM_LOADER_CKSUM_EN
  always_ff @(posedge clk_sys) begin
    if (reset || enter_load) rom_cksum <= 16'd0;
    else if (pop && (state == S_LOAD || state == S_FLUSH)) rom_cksum <= rom_cksum + {8'd0, head.data};
  end
`endif
endmodule
